// File: rtl/ifid_fetch_stage.sv
// ifid_fetch_stage: PC owner, single-outstanding imem fetch FSM and IF/ID pipeline register
module ifid_fetch_stage #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            IF_redo,
  input  logic            ID_redo,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] ifid_pc,
  output logic [XLEN-1:0] ifid_inst,
  output logic            ifid_valid
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
  state_t state, state_nx;
  logic [XLEN-1:0] pc, pc_nx, req_pc, req_pc_nx, buf_q, buf_nx, dlv_data, tgt;
  logic kill, kill_nx, deliver;
  assign tgt = {branch_target[XLEN-1:2], 2'b00};
  assign imem_req = (state == REQ) && !IF_redo && !branch_taken;
  assign imem_addr = pc;
  // kill marks an in-flight response that belongs to a squashed fetch
  always_comb begin
    state_nx = state;
    pc_nx = pc;
    req_pc_nx = req_pc;
    kill_nx = kill;
    buf_nx = buf_q;
    deliver = 1'b0;
    dlv_data = buf_q;
    case (state)
      IDLE: state_nx = REQ;
      REQ:
        if (branch_taken) pc_nx = tgt;
        else if (imem_req && imem_gnt) begin
          req_pc_nx = pc;
          state_nx = WAIT;
        end
      WAIT:
        if (branch_taken) begin
          pc_nx = tgt;
          kill_nx = !imem_rvalid;
          state_nx = imem_rvalid ? REQ : WAIT;
        end else if (imem_rvalid && kill) begin
          kill_nx = 1'b0;
          state_nx = REQ;
        end else if (imem_rvalid && !ID_redo) begin
          deliver = 1'b1;
          dlv_data = imem_rdata;
          pc_nx = req_pc + XLEN'(4);
          state_nx = REQ;
        end else if (imem_rvalid) begin
          buf_nx = imem_rdata;
          state_nx = HOLD;
        end
      HOLD:
        if (branch_taken) begin
          pc_nx = tgt;
          state_nx = REQ;
        end else if (!ID_redo) begin
          deliver = 1'b1;
          pc_nx = req_pc + XLEN'(4);
          state_nx = REQ;
        end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      req_pc <= '0;
      kill <= 1'b0;
      buf_q <= '0;
    end else begin
      state <= state_nx;
      pc <= pc_nx;
      req_pc <= req_pc_nx;
      kill <= kill_nx;
      buf_q <= buf_nx;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_pc <= '0;
      ifid_inst <= NOP;
      ifid_valid <= 1'b0;
    end else if (branch_taken) begin
      ifid_pc <= '0;
      ifid_inst <= NOP;
      ifid_valid <= 1'b0;
    end else if (!ID_redo) begin
      ifid_pc <= deliver ? req_pc : ifid_pc;
      ifid_inst <= deliver ? dlv_data : NOP;
      ifid_valid <= deliver;
    end
  end
endmodule

// File: tb/tb_ifid_fetch_stage.sv
// tb_ifid_fetch_stage: directed stimulus with scoreboard of expected IF/ID deliveries
module tb_ifid_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 0, rst_n = 0;
  logic IF_redo = 0, ID_redo = 0, branch_taken = 0;
  logic [31:0] branch_target = '0;
  logic imem_req, imem_gnt = 0, imem_rvalid = 0;
  logic [31:0] imem_addr, imem_rdata = '0, ifid_pc, ifid_inst;
  logic ifid_valid, prev_valid = 0;
  logic [63:0] sb[$];
  int n_chk = 0, n_fail = 0;

  ifid_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .IF_redo(IF_redo), .ID_redo(ID_redo),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .ifid_pc(ifid_pc), .ifid_inst(ifid_inst), .ifid_valid(ifid_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // a new delivery shows as a rising ifid_valid; deliveries are never back-to-back
  initial forever begin
    logic [63:0] e;
    @(negedge clk);
    if (ifid_valid && !prev_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_delivery: got pc %h inst %h expected none", ifid_pc, ifid_inst);
      end else begin
        e = sb.pop_front();
        chk("mon_pc", ifid_pc, e[63:32]);
        chk("mon_inst", ifid_inst, e[31:0]);
      end
    end
    prev_valid = ifid_valid;
  end

  // called at a negedge with the DUT in REQ; returns at the negedge after delivery
  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input int lat);
    imem_gnt = 1;
    #1;
    chk("fetch_req", imem_req, 1);
    chk("fetch_addr", imem_addr, a);
    @(negedge clk);
    imem_gnt = 0;
    repeat (lat - 1) @(negedge clk);
    imem_rvalid = 1;
    imem_rdata = d;
    sb.push_back({a, d});
    @(negedge clk);
    imem_rvalid = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", ifid_valid, 0);
    chk("rst_inst", ifid_inst, NOP);
    chk("rst_pc", ifid_pc, 0);
    chk("rst_req", imem_req, 0);
    rst_n = 1;
    @(negedge clk);
    // basic fetch, rvalid one cycle after grant
    fetch(32'h0, 32'h00A00093, 1);
    chk("t1_pc", ifid_pc, 32'h0);
    chk("t1_inst", ifid_inst, 32'h00A00093);
    chk("t1_valid", ifid_valid, 1);
    chk("t1_next_addr", imem_addr, 32'h4);
    fetch(32'h4, 32'h00200113, 2);
    // stall while response returns
    imem_gnt = 1;
    #1 chk("t2_addr", imem_addr, 32'h8);
    @(negedge clk);
    imem_gnt = 0;
    imem_rvalid = 1;
    imem_rdata = 32'h00112023;
    ID_redo = 1;
    IF_redo = 1;
    @(negedge clk);
    imem_rvalid = 0;
    imem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t2_stall_req", imem_req, 0);
      chk("t2_stall_valid", ifid_valid, 0);
      chk("t2_stall_pc", ifid_pc, 32'h4);
      chk("t2_stall_inst", ifid_inst, NOP);
      @(negedge clk);
    end
    ID_redo = 0;
    IF_redo = 0;
    sb.push_back({32'h8, 32'h00112023});
    @(negedge clk);
    chk("t2_pc", ifid_pc, 32'h8);
    chk("t2_next_addr", imem_addr, 32'hC);
    // branch while waiting; late response discarded
    imem_gnt = 1;
    @(negedge clk);
    imem_gnt = 0;
    branch_taken = 1;
    branch_target = 32'h103;
    #1 chk("t3_req_gated", imem_req, 0);
    @(negedge clk);
    branch_taken = 0;
    chk("t3_valid", ifid_valid, 0);
    chk("t3_inst", ifid_inst, NOP);
    chk("t3_pc", ifid_pc, 0);
    @(negedge clk);
    imem_rvalid = 1;
    imem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    imem_rvalid = 0;
    #1;
    chk("t3_valid_after", ifid_valid, 0);
    chk("t3_req", imem_req, 1);
    chk("t3_addr", imem_addr, 32'h100);
    @(negedge clk);
    fetch(32'h100, 32'h00500113, 1);
    // flush beats a stalled delivery in the same cycle
    imem_gnt = 1;
    @(negedge clk);
    imem_gnt = 0;
    imem_rvalid = 1;
    imem_rdata = 32'hBAADF00D;
    ID_redo = 1;
    IF_redo = 1;
    branch_taken = 1;
    branch_target = 32'h200;
    @(negedge clk);
    imem_rvalid = 0;
    ID_redo = 0;
    IF_redo = 0;
    branch_taken = 0;
    #1;
    chk("t4_valid", ifid_valid, 0);
    chk("t4_req", imem_req, 1);
    chk("t4_addr", imem_addr, 32'h200);
    @(negedge clk);
    fetch(32'h200, 32'h00300193, 1);
    // PC wrap
    branch_taken = 1;
    branch_target = 32'hFFFF_FFFE;
    @(negedge clk);
    branch_taken = 0;
    fetch(32'hFFFF_FFFC, 32'h00100213, 1);
    chk("t5_wrap_addr", imem_addr, 32'h0);
    fetch(32'h0, 32'h00700293, 1);
    // reset mid-transaction, stray rvalid afterwards
    imem_gnt = 1;
    #1 chk("t6_addr_pre", imem_addr, 32'h4);
    @(negedge clk);
    imem_gnt = 0;
    rst_n = 0;
    #1;
    chk("t6_rst_addr", imem_addr, 32'h0);
    chk("t6_rst_req", imem_req, 0);
    @(negedge clk);
    rst_n = 1;
    imem_rvalid = 1;
    imem_rdata = 32'h12345678;
    IF_redo = 1;
    @(negedge clk);
    @(negedge clk);
    imem_rvalid = 0;
    IF_redo = 0;
    #1;
    chk("t6_valid", ifid_valid, 0);
    chk("t6_addr", imem_addr, 32'h0);
    @(negedge clk);
    fetch(32'h0, 32'h00900313, 1);
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
